// File: rtl/id_fetch_queue_pkg.sv
// Types shared by the IF->ID queue: the packed fetch bus, the stored entry and decoder-facing fields.
// No logic; the one helper function is purely combinational.
// Backpressure is handled by the users of these types.
package id_fetch_queue_pkg;

    localparam logic [31:0] ID_NOP = 32'h0;

    typedef struct packed {
        logic [31:0] program_count;
        logic [31:0] instruction;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic        is_address_fault;
        logic        tlb_refill;
        logic        tlb_exception;
        logic [31:0] badvaddr;
    } id_queue_entry_t;

    // 106-bit IF->ID bus: valid qualifier followed by the storable payload.
    typedef struct packed {
        logic            valid;
        id_queue_entry_t pkt;
    } if_to_id_bus_t;

    typedef struct packed {
        logic            valid;
        id_queue_entry_t entry;
    } id_fetch_fields_t;

    // Empty head reads as all zeros; a faulting fetch must never reach the decoder as a real opcode.
    function automatic id_fetch_fields_t to_fetch_fields(input logic valid, input id_queue_entry_t e);
        id_fetch_fields_t f;
        f = '0;
        if (valid) begin
            f.valid = 1'b1;
            f.entry = e;
            if (e.exception_valid) begin
                f.entry.instruction = ID_NOP;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/id_fetch_queue_if.sv
// IF->ID handshake bundle: fetch bus and flush in, decoder fields and allow-in out.
// Master is the IF/control side, slave is the ID fetch queue.
// Backpressure: id_allow_in toward IF, ex_allow_in from downstream.
interface id_fetch_queue_if #(parameter int DEPTH = 2);
    import id_fetch_queue_pkg::*;

    localparam int OCC_W = $clog2(DEPTH + 1);

    if_to_id_bus_t    if_to_id_bus;
    logic             id_allow_in;
    logic             flush;
    logic             ex_allow_in;
    logic             id_valid;
    logic [31:0]      id_program_count;
    logic [31:0]      id_instruction;
    logic             id_exception_valid;
    logic [4:0]       id_exception_code;
    logic             id_is_address_fault;
    logic             id_tlb_refill;
    logic             id_tlb_exception;
    logic [31:0]      id_badvaddr;
    logic [OCC_W-1:0] id_occupancy;

    modport master (
        output if_to_id_bus, flush, ex_allow_in,
        input  id_allow_in, id_valid, id_program_count, id_instruction,
               id_exception_valid, id_exception_code, id_is_address_fault,
               id_tlb_refill, id_tlb_exception, id_badvaddr, id_occupancy
    );

    modport slave (
        input  if_to_id_bus, flush, ex_allow_in,
        output id_allow_in, id_valid, id_program_count, id_instruction,
               id_exception_valid, id_exception_code, id_is_address_fault,
               id_tlb_refill, id_tlb_exception, id_badvaddr, id_occupancy
    );

endinterface

// File: rtl/id_queue_pointer.sv
// Wrapping ring-buffer pointer with increment enable and synchronous clear.
// Latency: new value visible the cycle after inc/clear.
// Backpressure: none; callers gate inc.
module id_queue_pointer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_fetch_queue.sv
// DEPTH-entry IF->ID instruction queue presenting the oldest fetch to the decoder.
// Latency: push in cycle N visible in N+1; no IF->ID bypass.
// Backpressure: id_allow_in low when full or flushing; holds entries while ex_allow_in is low.
module id_fetch_queue
    import id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    id_fetch_queue_if.slave fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    id_queue_entry_t  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             allow_in;
    logic             has_entry;
    logic             push;
    logic             pop;
    id_fetch_fields_t head_fields;

    // Allow-in looks only at the registered count so IF never sees a path from ex_allow_in.
    assign allow_in  = !fq.flush && (count < FULL_COUNT);
    assign has_entry = (count != '0);
    assign push      = fq.if_to_id_bus.valid && allow_in;
    assign pop       = has_entry && fq.ex_allow_in && !fq.flush;

    id_queue_pointer #(.WIDTH(PTR_W)) u_head_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (fq.flush),
        .inc     (pop),
        .ptr     (head)
    );

    id_queue_pointer #(.WIDTH(PTR_W)) u_tail_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (fq.flush),
        .inc     (push),
        .ptr     (tail)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (fq.flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    // Payload storage carries no reset; validity lives entirely in count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= fq.if_to_id_bus.pkt;
        end
    end

    assign head_fields = to_fetch_fields(has_entry, mem[head]);

    assign fq.id_allow_in         = allow_in;
    assign fq.id_valid            = head_fields.valid;
    assign fq.id_program_count    = head_fields.entry.program_count;
    assign fq.id_instruction      = head_fields.entry.instruction;
    assign fq.id_exception_valid  = head_fields.entry.exception_valid;
    assign fq.id_exception_code   = head_fields.entry.exception_code;
    assign fq.id_is_address_fault = head_fields.entry.is_address_fault;
    assign fq.id_tlb_refill       = head_fields.entry.tlb_refill;
    assign fq.id_tlb_exception    = head_fields.entry.tlb_exception;
    assign fq.id_badvaddr         = head_fields.entry.badvaddr;
    assign fq.id_occupancy        = count;

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: directed vector table, reset-in-flight sequence, random run vs queue model.
module tb_id_fetch_queue;
    import id_fetch_queue_pkg::*;

    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    id_fetch_queue_if #(.DEPTH(DEPTH)) bus_if ();

    id_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fq      (bus_if.slave)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
        logic        af;
        logic [31:0] badv;
        logic        flush;
        logic        ex;
        logic        e_allow;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_exc;
        logic [4:0]  e_code;
        logic        e_af;
        logic [31:0] e_badv;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];
    id_queue_entry_t model_q[$];

    function automatic vec_t mk(input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                                input logic flush, input logic ex, input logic e_allow,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_inst, input logic [1:0] e_occ);
        vec_t v;
        v = '{default: '0};
        v.vld = vld; v.pc = pc; v.inst = inst; v.flush = flush; v.ex = ex;
        v.e_allow = e_allow; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input id_queue_entry_t e, input logic fl, input logic ex);
        bus_if.if_to_id_bus.valid = vld;
        bus_if.if_to_id_bus.pkt   = e;
        bus_if.flush              = fl;
        bus_if.ex_allow_in        = ex;
    endtask

    task automatic check_outputs(input string tag, input logic e_allow, input logic e_valid,
                                 input id_queue_entry_t e, input logic [1:0] e_occ);
        chk({tag, ".allow_in"},  32'(bus_if.id_allow_in),         32'(e_allow));
        chk({tag, ".valid"},     32'(bus_if.id_valid),            32'(e_valid));
        chk({tag, ".pc"},        bus_if.id_program_count,         e.program_count);
        chk({tag, ".inst"},      bus_if.id_instruction,           e.instruction);
        chk({tag, ".exc"},       32'(bus_if.id_exception_valid),  32'(e.exception_valid));
        chk({tag, ".code"},      32'(bus_if.id_exception_code),   32'(e.exception_code));
        chk({tag, ".addr_flt"},  32'(bus_if.id_is_address_fault), 32'(e.is_address_fault));
        chk({tag, ".refill"},    32'(bus_if.id_tlb_refill),       32'(e.tlb_refill));
        chk({tag, ".tlb_exc"},   32'(bus_if.id_tlb_exception),    32'(e.tlb_exception));
        chk({tag, ".badvaddr"},  bus_if.id_badvaddr,              e.badvaddr);
        chk({tag, ".occupancy"}, 32'(bus_if.id_occupancy),        32'(e_occ));
    endtask

    initial begin
        id_queue_entry_t e;
        id_queue_entry_t exp_e;
        id_queue_entry_t zero_e;
        vec_t v;
        logic vld, fl, ex, e_allow, do_push, do_pop;
        logic [31:0] pc_seq;

        zero_e = '0;
        drive(1'b0, zero_e, 1'b0, 1'b0);

        // Reset state
        #2 reset_n = 1'b0;
        #1 check_outputs("reset", 1'b1, 1'b0, zero_e, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors: inputs apply for one cycle; expectations are the state before that edge.
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 32'hBFC0_0000, 32'h2408_0001, 0, 1, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 1, 1, 1, 32'hBFC0_0000, 32'h2408_0001, 1));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 32'h100,       32'h1111_1111, 0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 32'h104,       32'h2222_2222, 0, 0, 1, 1, 32'h100,       32'h1111_1111, 1));
        vecs.push_back(mk(1, 32'h108,       32'h3333_3333, 0, 0, 0, 1, 32'h100,       32'h1111_1111, 2));
        vecs.push_back(mk(1, 32'h108,       32'h3333_3333, 0, 1, 0, 1, 32'h100,       32'h1111_1111, 2));
        vecs.push_back(mk(1, 32'h108,       32'h3333_3333, 0, 0, 1, 1, 32'h104,       32'h2222_2222, 1));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 1, 0, 1, 32'h104,       32'h2222_2222, 2));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 1, 1, 1, 32'h108,       32'h3333_3333, 1));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         32'h0,         0));
        v = mk(1, 32'h200, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0, 32'h0, 0);
        v.exc = 1; v.code = 5'h04; v.af = 1; v.badv = 32'h0000_0003;
        vecs.push_back(v);
        v = mk(0, 32'h0, 32'h0, 0, 1, 1, 1, 32'h200, 32'h0, 1);
        v.e_exc = 1; v.e_code = 5'h04; v.e_af = 1; v.e_badv = 32'h0000_0003;
        vecs.push_back(v);
        vecs.push_back(mk(1, 32'h300,       32'h4444_4444, 0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 32'h304,       32'h5555_5555, 0, 0, 1, 1, 32'h300,       32'h4444_4444, 1));
        vecs.push_back(mk(1, 32'h308,       32'h6666_6666, 1, 1, 0, 1, 32'h300,       32'h4444_4444, 2));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(1, 32'h400,       32'h7777_7777, 0, 0, 1, 0, 32'h0,         32'h0,         0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 1, 32'h400,       32'h7777_7777, 1));

        foreach (vecs[i]) begin
            @(negedge clock);
            e = '0;
            e.program_count = vecs[i].pc; e.instruction = vecs[i].inst;
            e.exception_valid = vecs[i].exc; e.exception_code = vecs[i].code;
            e.is_address_fault = vecs[i].af; e.badvaddr = vecs[i].badv;
            drive(vecs[i].vld, e, vecs[i].flush, vecs[i].ex);
            exp_e = '0;
            exp_e.program_count = vecs[i].e_pc; exp_e.instruction = vecs[i].e_inst;
            exp_e.exception_valid = vecs[i].e_exc; exp_e.exception_code = vecs[i].e_code;
            exp_e.is_address_fault = vecs[i].e_af; exp_e.badvaddr = vecs[i].e_badv;
            #1 check_outputs($sformatf("vec%0d", i), vecs[i].e_allow, vecs[i].e_valid, exp_e, vecs[i].e_occ);
        end

        // Reset asserted while one entry is held: contents vanish immediately.
        @(negedge clock);
        drive(1'b0, zero_e, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1 chk("midreset.valid", 32'(bus_if.id_valid), 32'd0);
        chk("midreset.occupancy", 32'(bus_if.id_occupancy), 32'd0);
        chk("midreset.pc", bus_if.id_program_count, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check_outputs("postreset", 1'b1, 1'b0, zero_e, 2'd0);

        // Random push/pop/flush against a plain FIFO model.
        model_q.delete();
        pc_seq = 32'h8000_0000;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clock);
            vld = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            ex  = ($urandom_range(0, 2) != 0);
            e = '0;
            e.program_count = pc_seq;
            e.instruction = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                e.exception_valid  = 1'b1;
                e.exception_code   = 5'($urandom);
                e.is_address_fault = 1'($urandom);
                e.tlb_refill       = 1'($urandom);
                e.tlb_exception    = 1'($urandom);
                e.badvaddr         = $urandom;
            end
            drive(vld, e, fl, ex);

            e_allow = !fl && (model_q.size() < DEPTH);
            exp_e = '0;
            if (model_q.size() > 0) begin
                exp_e = model_q[0];
                if (exp_e.exception_valid) exp_e.instruction = 32'h0;
            end
            #1 check_outputs($sformatf("rnd%0d", cyc), e_allow, model_q.size() > 0, exp_e,
                             2'(model_q.size()));

            do_push = vld && e_allow;
            do_pop  = (model_q.size() > 0) && ex && !fl;
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back(e);
            end
            if (do_push) pc_seq = pc_seq + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
